// File: rtl/qpsk_demodulator.sv
// ---------------------------------------------------------------------------
// qpsk_demodulator
//
// Coherent QPSK demodulator. Each symbol of the 9-bit carrier sample stream
// is correlated (integrate-and-dump) against internal cosine and sine
// references. The sign of each correlation gives the hard I/Q decision.
//
// Parameters
//   SAMPLES_PER_SYM : carrier samples per symbol, one carrier cycle per
//                     symbol (8 or 16)
//   ACC_W           : signed accumulator width (>= 21)
//
// Ports
//   clk           in   sample clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   sample_in     in   [8:0] signed carrier sample
//   sample_valid  in   sample_in consumed this cycle
//   sync_in       in   first sample of a symbol (one-cycle pulse)
//   I_demodulate  out  recovered I bit (registered, held until next dump)
//   Q_demodulate  out  recovered Q bit (registered, held until next dump)
//   sym_valid     out  one-cycle strobe, I/Q bits updated this cycle
//   lock          out  a full symbol has completed since the last sync_in
//   I_soft/Q_soft out  [ACC_W-1:0] signed correlations at the last dump
//                      (only when QPSK_DEMOD_SOFT_EN is defined)
//
// Build option
//   QPSK_DEMOD_SOFT_EN : adds the I_soft / Q_soft soft-decision outputs.
//
// States
//   state | meaning
//   IDLE  | waiting for the first sync_in, samples ignored, accumulators 0
//   RUN   | integrating valid samples, dumping every SAMPLES_PER_SYM samples
// ---------------------------------------------------------------------------
module qpsk_demodulator #(
    parameter int SAMPLES_PER_SYM = 16,
    parameter int ACC_W           = 21
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [8:0]       sample_in,
    input  logic             sample_valid,
    input  logic             sync_in,
    output logic             I_demodulate,
    output logic             Q_demodulate,
    output logic             sym_valid,
    output logic             lock
`ifdef QPSK_DEMOD_SOFT_EN
    ,
    output logic [ACC_W-1:0] I_soft,
    output logic [ACC_W-1:0] Q_soft
`endif
);

    if (!(SAMPLES_PER_SYM == 8 || SAMPLES_PER_SYM == 16)) begin : g_bad_sps
        $error("qpsk_demodulator: SAMPLES_PER_SYM must be 8 or 16");
    end

    if (ACC_W < 21) begin : g_bad_acc_w
        $error("qpsk_demodulator: ACC_W must be at least 21");
    end

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // round(127*cos(2*pi*k/16))
    function automatic logic signed [7:0] cos_rom(input logic [3:0] k);
        logic signed [7:0] v;
        case (k)
            4'd0:    v =  8'sd127;
            4'd1:    v =  8'sd117;
            4'd2:    v =  8'sd90;
            4'd3:    v =  8'sd49;
            4'd4:    v =  8'sd0;
            4'd5:    v = -8'sd49;
            4'd6:    v = -8'sd90;
            4'd7:    v = -8'sd117;
            4'd8:    v = -8'sd127;
            4'd9:    v = -8'sd117;
            4'd10:   v = -8'sd90;
            4'd11:   v = -8'sd49;
            4'd12:   v =  8'sd0;
            4'd13:   v =  8'sd49;
            4'd14:   v =  8'sd90;
            default: v =  8'sd117;
        endcase
        return v;
    endfunction

    // sin(x) = cos(x - pi/2): a quarter-table shift of the cosine ROM,
    // identical to round(127*sin(2*pi*k/16)) entry for entry.
    function automatic logic signed [7:0] sin_rom(input logic [3:0] k);
        return cos_rom(k - 4'd4);
    endfunction

    state_t                  state_q, state_d;
    logic [3:0]              phase_q, phase_d;
    logic signed [ACC_W-1:0] acc_i_q, acc_i_d;
    logic signed [ACC_W-1:0] acc_q_q, acc_q_d;
    logic                    i_bit_q, i_bit_d;
    logic                    q_bit_q, q_bit_d;
    logic                    sym_valid_q, sym_valid_d;
    logic                    lock_q, lock_d;
`ifdef QPSK_DEMOD_SOFT_EN
    logic signed [ACC_W-1:0] soft_i_q, soft_i_d;
    logic signed [ACC_W-1:0] soft_q_q, soft_q_d;
`endif

    logic [3:0]              phase_eff;
    logic [3:0]              rom_idx;
    logic signed [7:0]       cos_val;
    logic signed [7:0]       sin_val;
    logic signed [16:0]      prod_i;
    logic signed [16:0]      prod_q;
    logic signed [ACC_W-1:0] prod_i_ext;
    logic signed [ACC_W-1:0] prod_q_ext;
    logic signed [ACC_W-1:0] final_i;
    logic signed [ACC_W-1:0] final_q;
    logic                    is_last;

    // A sync_in sample is phase 0 of the new symbol, whatever phase_q holds.
    assign phase_eff = sync_in ? 4'd0 : phase_q;
    assign rom_idx   = (SAMPLES_PER_SYM == 16) ? phase_eff : {phase_eff[2:0], 1'b0};
    assign cos_val   = cos_rom(rom_idx);
    assign sin_val   = sin_rom(rom_idx);

    assign prod_i     = $signed(sample_in) * cos_val;
    assign prod_q     = $signed(sample_in) * sin_val;
    assign prod_i_ext = {{(ACC_W-17){prod_i[16]}}, prod_i};
    assign prod_q_ext = {{(ACC_W-17){prod_q[16]}}, prod_q};
    assign final_i    = acc_i_q + prod_i_ext;
    assign final_q    = acc_q_q + prod_q_ext;
    assign is_last    = (phase_q == 4'(SAMPLES_PER_SYM - 1));

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        acc_i_d     = acc_i_q;
        acc_q_d     = acc_q_q;
        i_bit_d     = i_bit_q;
        q_bit_d     = q_bit_q;
        sym_valid_d = 1'b0;
        lock_d      = lock_q;
`ifdef QPSK_DEMOD_SOFT_EN
        soft_i_d    = soft_i_q;
        soft_q_d    = soft_q_q;
`endif
        // sync_in has priority over a coincident dump: the old symbol is dropped.
        if (sync_in) begin
            state_d = ST_RUN;
            lock_d  = 1'b0;
            if (sample_valid) begin
                phase_d = 4'd1;
                acc_i_d = prod_i_ext;
                acc_q_d = prod_q_ext;
            end else begin
                phase_d = 4'd0;
                acc_i_d = '0;
                acc_q_d = '0;
            end
        end else if (state_q == ST_RUN && sample_valid) begin
            if (is_last) begin
                phase_d     = 4'd0;
                acc_i_d     = '0;
                acc_q_d     = '0;
                // Zero correlation decides 0.
                i_bit_d     = !final_i[ACC_W-1] && (final_i != '0);
                q_bit_d     = !final_q[ACC_W-1] && (final_q != '0);
                sym_valid_d = 1'b1;
                lock_d      = 1'b1;
`ifdef QPSK_DEMOD_SOFT_EN
                soft_i_d    = final_i;
                soft_q_d    = final_q;
`endif
            end else begin
                phase_d = phase_q + 4'd1;
                acc_i_d = final_i;
                acc_q_d = final_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            phase_q     <= 4'd0;
            acc_i_q     <= '0;
            acc_q_q     <= '0;
            i_bit_q     <= 1'b0;
            q_bit_q     <= 1'b0;
            sym_valid_q <= 1'b0;
            lock_q      <= 1'b0;
`ifdef QPSK_DEMOD_SOFT_EN
            soft_i_q    <= '0;
            soft_q_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            acc_i_q     <= acc_i_d;
            acc_q_q     <= acc_q_d;
            i_bit_q     <= i_bit_d;
            q_bit_q     <= q_bit_d;
            sym_valid_q <= sym_valid_d;
            lock_q      <= lock_d;
`ifdef QPSK_DEMOD_SOFT_EN
            soft_i_q    <= soft_i_d;
            soft_q_q    <= soft_q_d;
`endif
        end
    end

    assign I_demodulate = i_bit_q;
    assign Q_demodulate = q_bit_q;
    assign sym_valid    = sym_valid_q;
    assign lock         = lock_q;
`ifdef QPSK_DEMOD_SOFT_EN
    assign I_soft       = soft_i_q;
    assign Q_soft       = soft_q_q;
`endif

endmodule

// File: tb/tb_qpsk_demodulator.sv
// ---------------------------------------------------------------------------
// tb_qpsk_demodulator
//
// Drives a 16-sample/symbol and an 8-sample/symbol demodulator. Expected
// outputs come from a symbol-level reference: samples since the last sync
// are collected, and at the end of a symbol the correlations are computed
// directly from rounded 127*cos / 127*sin of the carrier angle.
// Soft outputs are checked when QPSK_DEMOD_SOFT_EN is defined.
// ---------------------------------------------------------------------------
module tb_qpsk_demodulator;

    localparam real PI = 3.14159265358979323846;

    logic        clk;
    logic        rst_n;
    logic [8:0]  s16, s8;
    logic        v16, v8, y16, y8;
    logic        i16, q16, sv16, lk16;
    logic        i8, q8, sv8, lk8;
`ifdef QPSK_DEMOD_SOFT_EN
    logic [20:0] si16, sq16, si8, sq8;
`endif

    qpsk_demodulator #(.SAMPLES_PER_SYM(16), .ACC_W(21)) dut16 (
        .clk(clk), .rst_n(rst_n), .sample_in(s16), .sample_valid(v16), .sync_in(y16),
        .I_demodulate(i16), .Q_demodulate(q16), .sym_valid(sv16), .lock(lk16)
`ifdef QPSK_DEMOD_SOFT_EN
        , .I_soft(si16), .Q_soft(sq16)
`endif
    );

    qpsk_demodulator #(.SAMPLES_PER_SYM(8), .ACC_W(21)) dut8 (
        .clk(clk), .rst_n(rst_n), .sample_in(s8), .sample_valid(v8), .sync_in(y8),
        .I_demodulate(i8), .Q_demodulate(q8), .sym_valid(sv8), .lock(lk8)
`ifdef QPSK_DEMOD_SOFT_EN
        , .I_soft(si8), .Q_soft(sq8)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model state, index 0 = 16-sample DUT, 1 = 8-sample DUT.
    bit running [2];
    int cnt     [2];
    int samp    [2][16];
    bit e_i     [2];
    bit e_q     [2];
    bit e_sv    [2];
    bit e_lock  [2];
    int e_soft_i[2];
    int e_soft_q[2];

    int strobes16, strobes8;
    int last_sv16;
    bit spacing_on;

    function automatic int sps_of(input int d);
        return (d == 0) ? 16 : 8;
    endfunction

    function automatic int rnd(input real x);
        return $rtoi($floor(x + 0.5));
    endfunction

    function automatic int ref_cos(input int k);
        return rnd(127.0 * $cos(2.0 * PI * k / 16.0));
    endfunction

    function automatic int ref_sin(input int k);
        return rnd(127.0 * $sin(2.0 * PI * k / 16.0));
    endfunction

    // Carrier sample n of a symbol with amplitudes (ia, qa); kind 1 is DC ia.
    function automatic logic [8:0] sym_sample(input int kind, input int ia, input int qa,
                                              input int n, input int sps);
        int v;
        real ph;
        ph = 2.0 * PI * n / sps;
        if (kind == 1) v = ia;
        else           v = rnd(ia * $cos(ph)) + rnd(qa * $sin(ph));
        return 9'(v);
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            running[d] = 0; cnt[d] = 0; e_i[d] = 0; e_q[d] = 0;
            e_sv[d] = 0; e_lock[d] = 0; e_soft_i[d] = 0; e_soft_q[d] = 0;
        end
    endtask

    task automatic model_step(input int d, input bit v, input int s, input bit sy);
        int ci, cq, sps;
        sps = sps_of(d);
        e_sv[d] = 0;
        if (sy) begin
            running[d] = 1;
            e_lock[d]  = 0;
            cnt[d]     = 0;
            if (v) begin
                samp[d][0] = s;
                cnt[d] = 1;
            end
        end else if (running[d] && v) begin
            samp[d][cnt[d]] = s;
            cnt[d]++;
            if (cnt[d] == sps) begin
                ci = 0; cq = 0;
                for (int n = 0; n < sps; n++) begin
                    ci += samp[d][n] * ref_cos(n * 16 / sps);
                    cq += samp[d][n] * ref_sin(n * 16 / sps);
                end
                e_i[d] = (ci > 0);
                e_q[d] = (cq > 0);
                e_soft_i[d] = ci;
                e_soft_q[d] = cq;
                e_sv[d] = 1;
                e_lock[d] = 1;
                cnt[d] = 0;
            end
        end
    endtask

    task automatic check_outputs(input int d);
        if (d == 0) begin
            chk("sym_valid16", sv16, e_sv[0]);
            chk("lock16", lk16, e_lock[0]);
            chk("i16", i16, e_i[0]);
            chk("q16", q16, e_q[0]);
`ifdef QPSK_DEMOD_SOFT_EN
            chk("i_soft16", $signed(si16), e_soft_i[0]);
            chk("q_soft16", $signed(sq16), e_soft_q[0]);
`endif
            if (sv16) begin
                strobes16++;
                if (spacing_on && last_sv16 >= 0) chk("strobe_spacing", cyc - last_sv16, 16);
                last_sv16 = cyc;
            end
        end else begin
            chk("sym_valid8", sv8, e_sv[1]);
            chk("lock8", lk8, e_lock[1]);
            chk("i8", i8, e_i[1]);
            chk("q8", q8, e_q[1]);
`ifdef QPSK_DEMOD_SOFT_EN
            chk("i_soft8", $signed(si8), e_soft_i[1]);
            chk("q_soft8", $signed(sq8), e_soft_q[1]);
`endif
            if (sv8) strobes8++;
        end
    endtask

    // Called just after a negedge: drive, clock, update model, check at negedge.
    task automatic step(input int d, input bit v, input logic [8:0] s, input bit sy);
        if (d == 0) begin
            v16 = v; s16 = s; y16 = sy; v8 = 1'b0; y8 = 1'b0;
        end else begin
            v8 = v; s8 = s; y8 = sy; v16 = 1'b0; y16 = 1'b0;
        end
        @(posedge clk);
        cyc++;
        model_step(d, v, int'($signed(s)), sy);
        @(negedge clk);
        check_outputs(d);
    endtask

    task automatic send_symbol(input int d, input int kind, input int ia, input int qa,
                               input bit sync_first);
        for (int n = 0; n < sps_of(d); n++)
            step(d, 1'b1, sym_sample(kind, ia, qa, n, sps_of(d)), sync_first && n == 0);
    endtask

    typedef struct {
        int kind;
        int ia;
        int qa;
        bit exp_i;
        bit exp_q;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int k0, strobe_at;

        tbl[0] = '{0,  100,  100, 1'b1, 1'b1};
        tbl[1] = '{0, -100,  100, 1'b0, 1'b1};
        tbl[2] = '{0, -100, -100, 1'b0, 1'b0};
        tbl[3] = '{0,  100, -100, 1'b1, 1'b0};
        tbl[4] = '{1,  255,    0, 1'b0, 1'b0};
        tbl[5] = '{0,   60,  -90, 1'b1, 1'b0};

        rst_n = 1'b0;
        s16 = '0; s8 = '0; v16 = 1'b0; v8 = 1'b0; y16 = 1'b0; y8 = 1'b0;
        strobes16 = 0; strobes8 = 0; last_sv16 = -1; spacing_on = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs(0);
        check_outputs(1);
        rst_n = 1'b1;

        // Back-to-back table symbols, sample_valid held high, one sync up front.
        spacing_on = 1;
        for (int t = 0; t < 6; t++) begin
            send_symbol(0, tbl[t].kind, tbl[t].ia, tbl[t].qa, t == 0);
            chk("tbl_strobe", sv16, 1);
            chk("tbl_i", i16, tbl[t].exp_i);
            chk("tbl_q", q16, tbl[t].exp_q);
            chk("tbl_lock", lk16, 1);
        end
        spacing_on = 0;
        chk("tbl_strobe_count", strobes16, 6);

        // Resync after 7 samples: partial symbol dropped, lock falls.
        strobes16 = 0;
        for (int n = 0; n < 7; n++) step(0, 1'b1, sym_sample(0, 100, -100, n, 16), 1'b0);
        step(0, 1'b1, sym_sample(0, -100, 100, 0, 16), 1'b1);
        chk("resync_lock_drop", lk16, 0);
        for (int n = 1; n < 16; n++) step(0, 1'b1, sym_sample(0, -100, 100, n, 16), 1'b0);
        chk("resync_strobe_count", strobes16, 1);
        chk("resync_i", i16, 0);
        chk("resync_q", q16, 1);

        // sync_in coinciding with the dump sample wins.
        send_symbol(0, 0, 100, 100, 1'b1);
        for (int n = 0; n < 15; n++) step(0, 1'b1, sym_sample(0, 100, 100, n, 16), n == 0);
        step(0, 1'b1, sym_sample(0, 100, -100, 0, 16), 1'b1);
        chk("collide_no_strobe", sv16, 0);
        chk("collide_lock", lk16, 0);
        for (int n = 1; n < 16; n++) step(0, 1'b1, sym_sample(0, 100, -100, n, 16), 1'b0);
        chk("collide_after_i", i16, 1);
        chk("collide_after_q", q16, 0);

        // Reset mid-symbol with sample_valid high.
        send_symbol(0, 0, 100, 100, 1'b1);
        for (int n = 0; n < 5; n++) step(0, 1'b1, sym_sample(0, 100, 100, n, 16), 1'b0);
        #2 rst_n = 1'b0;
        v16 = 1'b1;
        #1;
        chk("rst_i", i16, 0);
        chk("rst_q", q16, 0);
        chk("rst_sv", sv16, 0);
        chk("rst_lock", lk16, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        strobes16 = 0;
        for (int n = 0; n < 20; n++) step(0, 1'b1, sym_sample(0, 100, 100, n % 16, 16), 1'b0);
        chk("no_sync_no_strobe", strobes16, 0);

        // Gapped input on the 8-sample DUT: valid toggles 1,0.
        for (int r = 0; r < 2; r++) begin
            strobe_at = -1;
            for (int k = 0; k < 15; k++) begin
                step(1, (k % 2) == 0,
                     sym_sample(0, (r == 0) ? 100 : -100, (r == 0) ? -100 : 100, k / 2, 8),
                     k == 0);
                if (sv8 && strobe_at < 0) strobe_at = k + 1;
            end
            chk("gap_dump_cycles", strobe_at, 15);
            chk("gap_i", i8, (r == 0) ? 1 : 0);
            chk("gap_q", q8, (r == 0) ? 0 : 1);
            step(1, 1'b0, '0, 1'b0);
        end

        // Random samples, gaps and occasional resyncs on both DUTs.
        for (int d = 0; d < 2; d++) begin
            k0 = (d == 0) ? strobes16 : strobes8;
            step(d, 1'b1, 9'($urandom), 1'b1);
            for (int n = 0; n < 900; n++)
                step(d, ($urandom % 4) != 0, 9'($urandom), ($urandom % 45) == 0);
            chk("random_some_strobes", (((d == 0) ? strobes16 : strobes8) - k0) > 0, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/qpsk_demodulator.md
# qpsk_demodulator

Coherent QPSK demodulator that consumes the 9-bit carrier sample stream produced by the QPSK modulation stage and recovers the I and Q bit channels. Each symbol is integrate-and-dumped against internal cosine and sine references, and a hard decision is made on each sign. The block sits directly downstream of the modulator in the top-level loopback path and drives the `I_demodulate` / `Q_demodulate` outputs.

## Interface
- `SAMPLES_PER_SYM`, default 16: carrier samples per symbol, with one carrier cycle per symbol. Legal values are 8 and 16; any other value is a synthesis error.
- `ACC_W`, default 21: signed accumulator width. Minimum is 21; smaller values are a synthesis error.

Ports:
- `clk`, input, 1: sample clock. All state is updated on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `sample_in`, input, 9: carrier sample, signed two's complement.
- `sample_valid`, input, 1: `sample_in` is consumed on every cycle where this is high.
- `sync_in`, input, 1: one-cycle pulse marking the first sample of a symbol.
- `I_demodulate`, output, 1: recovered I bit, registered.
- `Q_demodulate`, output, 1: recovered Q bit, registered.
- `sym_valid`, output, 1: one-cycle strobe; the I/Q bits were updated this cycle.
- `lock`, output, 1: at least one full symbol has completed since the last `sync_in`.

## Operation
- **Reference tables.** Two internal ROMs hold 16 signed 8-bit entries each.
  - `cos[k] = round(127*cos(2πk/16))`
  - `sin[k] = round(127*sin(2πk/16))`
  - The index is `phase*(16/SAMPLES_PER_SYM)`.
- **State machine.** There are two states, IDLE and RUN.
  - IDLE: samples are ignored and the accumulators are held at 0. A `sync_in` pulse moves the block to RUN.
  - RUN: each valid sample adds `sample_in*cos[idx]` to `acc_i` and `sample_in*sin[idx]` to `acc_q`, then increments `phase`.
  - `sample_valid` low means the block holds its state, with no timeout.
- **Product width.** Each product is 17 bits signed and is sign-extended to `ACC_W`. At most 16 × 255 × 127 = 518,160, so there is no overflow at 21 bits.
- **Dump.** The dump happens on a valid sample where `phase == SAMPLES_PER_SYM-1`. On that same edge:
  - `I_demodulate <= (final_i > 0)` and `Q_demodulate <= (final_q > 0)`, where `final` is the accumulator plus the current product. A zero correlation decides 0.
  - `sym_valid <= 1`.
  - `lock <= 1`.
  - `phase` wraps to 0 and both accumulators clear to 0.
- **Resync in RUN.** A `sync_in` while in RUN restarts the symbol:
  - `phase` goes to 0 and the accumulators clear.
  - The partial symbol is discarded with no `sym_valid`, and `lock` clears.
  - If `sample_valid` is high in the same cycle, that sample is used as phase 0 of the new symbol.
- **Simultaneous dump and sync.** If `sync_in` and the dump condition occur together, `sync_in` wins and the old symbol is discarded.
- **Reset values.** Asynchronous reset forces:
  - state IDLE, `phase` = 0, accumulators = 0;
  - `I_demodulate`, `Q_demodulate`, `sym_valid` and `lock` all 0.
- **Reset mid-symbol.** A reset during a symbol discards it; a new `sync_in` is needed afterwards.

## Timing
- **Latency.** The final valid sample of a symbol is captured on edge t. The decision bits and `sym_valid` are visible after edge t and are high during cycle t+1.
- **Strobe width.** `sym_valid` is high for exactly one cycle per completed symbol.
- **Held bits.** The I/Q bits hold their value until the next dump.
- **Throughput.** Back-to-back symbols are supported at one sample per clock with no bubble. The first sample of the next symbol may arrive in the cycle after the dump sample.
- **Minimum symbol spacing.** Symbols are at least `SAMPLES_PER_SYM` valid samples apart, so `sym_valid` never fires on consecutive cycles.
- **Reset timing.** `rst_n` assertion takes effect immediately. Release is synchronised externally by the system; the block samples nothing on the edge where `rst_n` rises.

## Configuration
- **`QPSK_DEMOD_SOFT_EN` defined:**
  - Adds output ports `I_soft` and `Q_soft`, each `ACC_W` bits signed.
  - They are loaded with `final_i` / `final_q` on the dump edge and hold until the next dump.
  - Both reset to 0.
- **`QPSK_DEMOD_SOFT_EN` undefined:** these ports and registers do not exist. Hard-decision behaviour is identical in both builds.

## Test plan
- **Reset.** Assert `rst_n` = 0 mid-symbol with `sample_valid` high → all outputs 0 immediately; after release, samples without `sync_in` produce no `sym_valid`.
- **Single symbol.** `sync_in` plus 16 samples of `round(100*cos)+round(100*sin)` (I=1, Q=1) → one `sym_valid` in the cycle after the 16th sample, with `I_demodulate`=1 and `Q_demodulate`=1. With soft outputs built in, `I_soft` ≈ +101,600.
- **All four symbols.** Back-to-back symbols (1,1), (0,1), (0,0), (1,0) with the ±100 amplitude and `sample_valid` held high → 4 strobes spaced exactly 16 cycles apart, with matching bits.
- **DC input.** A constant `sample_in` = +255 for one symbol → correlations 0 and 0, so the bits decide 0,0. `sym_valid` still pulses and `lock` = 1.
- **Resync mid-symbol.** `sync_in` re-pulsed after 7 samples → no strobe for the partial symbol and `lock` drops. The next strobe arrives 16 valid samples after the resync, with the correct bits.
- **Gapped input.** `sample_valid` toggling 1,0 and `SAMPLES_PER_SYM` = 8 → the dump occurs after 8 valid samples (15 cycles), with correct decisions.
